// File: rtl/lfst_invld_sched_pkg.sv
// Shared retire-path constants and helpers for LFST invalidate scheduling.
package lfst_invld_sched_pkg;

  localparam int INUM_W           = 7;
  localparam int RET_WIDTH        = 4;
  localparam int LFST_INVLD_PORTS = 2;

  // Number of set bits in a 4-wide retire valid vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/lfst_invld_compact.sv
// Packs the valid retire slots, in slot order, into a dense list of inums
// plus a count of how many are valid.
module lfst_invld_compact #(
  parameter int INUM_W = 7
) (
  input  logic [lfst_invld_sched_pkg::RET_WIDTH-1:0] vld,
  input  logic [INUM_W-1:0] inum      [lfst_invld_sched_pkg::RET_WIDTH],
  output logic [INUM_W-1:0] pack_inum [lfst_invld_sched_pkg::RET_WIDTH],
  output logic [2:0]        cnt
);
  import lfst_invld_sched_pkg::*;

  logic [2:0] slot;

  // Walk slots oldest first; each valid slot takes the next free packed position.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    pack_inum = '{default: '0};
    slot      = '0;
    for (int i = 0; i < RET_WIDTH; i++) begin
      if (vld[i]) begin
        pack_inum[slot[1:0]] = inum[i];
        slot                 = slot + 3'd1;
      end
    end
    cnt = popcount4(vld);
  end

endmodule

// File: rtl/lfst_invld_sched.sv
// Buffers up to 4 retiring-store inums per cycle in an in-order queue and
// drains up to 2 per cycle onto the LFST invalidate ports.
module lfst_invld_sched #(
  parameter int DEPTH  = 8,
  parameter int INUM_W = 7,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              ret0_st_vld_i,
  input  logic              ret1_st_vld_i,
  input  logic              ret2_st_vld_i,
  input  logic              ret3_st_vld_i,
  input  logic [INUM_W-1:0] ret0_inum_i,
  input  logic [INUM_W-1:0] ret1_inum_i,
  input  logic [INUM_W-1:0] ret2_inum_i,
  input  logic [INUM_W-1:0] ret3_inum_i,
  output logic              ready_o,
  output logic              lfst_invld0_o,
  output logic [INUM_W-1:0] lfst_invld0_idx_o,
  output logic              lfst_invld1_o,
  output logic [INUM_W-1:0] lfst_invld1_idx_o,
  output logic [CNT_W-1:0]  occupancy_o
);
  import lfst_invld_sched_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [INUM_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  logic [RET_WIDTH-1:0] ret_vld;
  logic [INUM_W-1:0]    ret_inum  [RET_WIDTH];
  logic [INUM_W-1:0]    pack_inum [RET_WIDTH];
  logic [2:0]           nenq_raw;
  logic [2:0]           nenq;
  logic [1:0]           ndeq;
  logic                 enq_en;
  logic [PTR_W-1:0]     head_p1;

  assign ret_vld  = {ret3_st_vld_i, ret2_st_vld_i, ret1_st_vld_i, ret0_st_vld_i};
  assign ret_inum = '{ret0_inum_i, ret1_inum_i, ret2_inum_i, ret3_inum_i};

  lfst_invld_compact #(.INUM_W(INUM_W)) u_compact (
    .vld       (ret_vld),
    .inum      (ret_inum),
    .pack_inum (pack_inum),
    .cnt       (nenq_raw)
  );

  // Ready depends on registered count only: room for a full bundle after no drain.
  assign ready_o = (count <= CNT_W'(DEPTH - RET_WIDTH));
  assign enq_en  = ready_o && !flush_i;
  assign nenq    = enq_en ? nenq_raw : 3'd0;
  assign ndeq    = (count >= CNT_W'(LFST_INVLD_PORTS)) ? 2'd2 :
                   (count != '0)                       ? 2'd1 : 2'd0;
  assign head_p1 = head + PTR_W'(1);

  // Drain ports are driven straight from registered state; no same-cycle bypass.
  assign lfst_invld0_o     = (count >= CNT_W'(1));
  assign lfst_invld1_o     = (count >= CNT_W'(2));
  assign lfst_invld0_idx_o = lfst_invld0_o ? mem[head]    : '0;
  assign lfst_invld1_idx_o = lfst_invld1_o ? mem[head_p1] : '0;
  assign occupancy_o       = count;

  // Pointer and occupancy update; reset and flush both discard all pending work.
  // NOTE: sequential state is assigned with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset_n || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(ndeq);
      tail  <= tail + PTR_W'(nenq);
      count <= count + CNT_W'(nenq) - CNT_W'(ndeq);
    end
  end

  // Entry writes: packed inums land at tail, tail+1, ... with natural wrap.
  // NOTE: the entry array has no reset; count gates every read of stale data.
  always_ff @(posedge clock) begin
    for (int i = 0; i < RET_WIDTH; i++) begin
      if (enq_en && (3'(i) < nenq_raw)) begin
        mem[tail + PTR_W'(i)] <= pack_inum[i];
      end
    end
  end

  a_count_max: assert property (@(posedge clock) disable iff (!reset_n)
    count <= CNT_W'(DEPTH));
  a_no_enq_blocked: assert property (@(posedge clock) disable iff (!reset_n)
    !ready_o |-> (nenq == 3'd0));
  a_empty_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    (count == '0) |-> (!lfst_invld0_o && !lfst_invld1_o));

endmodule

// File: tb/tb_lfst_invld_sched.sv
// Directed bench for lfst_invld_sched with hand-computed expected outputs.
module tb_lfst_invld_sched;

  localparam int DEPTH  = 8;
  localparam int INUM_W = 7;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset_n;
  logic              flush_i;
  logic              ret0_st_vld_i, ret1_st_vld_i, ret2_st_vld_i, ret3_st_vld_i;
  logic [INUM_W-1:0] ret0_inum_i, ret1_inum_i, ret2_inum_i, ret3_inum_i;
  logic              ready_o;
  logic              lfst_invld0_o;
  logic [INUM_W-1:0] lfst_invld0_idx_o;
  logic              lfst_invld1_o;
  logic [INUM_W-1:0] lfst_invld1_idx_o;
  logic [CNT_W-1:0]  occupancy_o;

  int checks = 0;
  int errors = 0;

  lfst_invld_sched #(.DEPTH(DEPTH), .INUM_W(INUM_W), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .flush_i           (flush_i),
    .ret0_st_vld_i     (ret0_st_vld_i),
    .ret1_st_vld_i     (ret1_st_vld_i),
    .ret2_st_vld_i     (ret2_st_vld_i),
    .ret3_st_vld_i     (ret3_st_vld_i),
    .ret0_inum_i       (ret0_inum_i),
    .ret1_inum_i       (ret1_inum_i),
    .ret2_inum_i       (ret2_inum_i),
    .ret3_inum_i       (ret3_inum_i),
    .ready_o           (ready_o),
    .lfst_invld0_o     (lfst_invld0_o),
    .lfst_invld0_idx_o (lfst_invld0_idx_o),
    .lfst_invld1_o     (lfst_invld1_o),
    .lfst_invld1_idx_o (lfst_invld1_idx_o),
    .occupancy_o       (occupancy_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one retire bundle (vld bit i = slot i).
  task automatic set_ret(input logic [3:0] vld, input int a, input int b,
                         input int c, input int d);
    {ret3_st_vld_i, ret2_st_vld_i, ret1_st_vld_i, ret0_st_vld_i} = vld;
    ret0_inum_i = INUM_W'(a);
    ret1_inum_i = INUM_W'(b);
    ret2_inum_i = INUM_W'(c);
    ret3_inum_i = INUM_W'(d);
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input int v0, input int i0,
                            input int v1, input int i1, input int occ,
                            input int rdy);
    check({tag, ".invld0"}, int'(lfst_invld0_o), v0);
    check({tag, ".idx0"},   int'(lfst_invld0_idx_o), i0);
    check({tag, ".invld1"}, int'(lfst_invld1_o), v1);
    check({tag, ".idx1"},   int'(lfst_invld1_idx_o), i1);
    check({tag, ".occ"},    int'(occupancy_o), occ);
    check({tag, ".ready"},  int'(ready_o), rdy);
  endtask

  initial begin
    reset_n = 1'b0;
    flush_i = 1'b0;
    set_ret(4'b0000, 0, 0, 0, 0);

    // Reset then idle.
    step();
    expect_out("reset", 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;
    step();
    expect_out("idle", 0, 0, 0, 0, 0, 1);

    // Single store on slot 0.
    set_ret(4'b0001, 'h15, 0, 0, 0);
    step();
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("single", 1, 'h15, 0, 0, 1, 1);
    step();
    expect_out("single_drained", 0, 0, 0, 0, 0, 1);

    // Full-bundle burst: 1,2,3,4 held across the ready drop.
    set_ret(4'b1111, 1, 2, 3, 4);
    step();
    expect_out("burst_c1", 1, 1, 1, 2, 4, 1);
    step();
    expect_out("burst_c2", 1, 3, 1, 4, 6, 0);
    step();
    expect_out("burst_c3", 1, 1, 1, 2, 4, 1);
    set_ret(4'b0000, 0, 0, 0, 0);
    step();
    expect_out("burst_c4", 1, 3, 1, 4, 2, 1);
    step();
    expect_out("burst_done", 0, 0, 0, 0, 0, 1);

    // Sparse compaction: slots 1 and 3 only.
    set_ret(4'b1010, 'h11, 'h22, 'h44, 'h33);
    step();
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("sparse", 1, 'h22, 1, 'h33, 2, 1);
    step();
    expect_out("sparse_done", 0, 0, 0, 0, 0, 1);

    // Wrap: head/tail are at 3; four fillers move them to 7.
    set_ret(4'b1111, 'h40, 'h41, 'h42, 'h43);
    step();
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("fill_c1", 1, 'h40, 1, 'h41, 4, 1);
    step();
    expect_out("fill_c2", 1, 'h42, 1, 'h43, 2, 1);
    step();
    expect_out("fill_done", 0, 0, 0, 0, 0, 1);
    set_ret(4'b0011, 9, 10, 0, 0);
    step();
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("wrap", 1, 9, 1, 10, 2, 1);
    step();
    expect_out("wrap_done", 0, 0, 0, 0, 0, 1);

    // Flush mid-drain with occupancy 5 and a bundle presented.
    set_ret(4'b1111, 'h50, 'h51, 'h52, 'h53);
    step();
    expect_out("pre_flush_c1", 1, 'h50, 1, 'h51, 4, 1);
    set_ret(4'b0111, 'h54, 'h55, 'h56, 0);
    step();
    expect_out("pre_flush_c2", 1, 'h52, 1, 'h53, 5, 0);
    flush_i = 1'b1;
    set_ret(4'b1111, 'h60, 'h61, 'h62, 'h63);
    #1;
    expect_out("flush_cycle", 1, 'h52, 1, 'h53, 5, 0);
    step();
    flush_i = 1'b0;
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("post_flush", 0, 0, 0, 0, 0, 1);
    step();
    expect_out("post_flush_idle", 0, 0, 0, 0, 0, 1);

    // Flush while ready=1 must still suppress the enqueue.
    set_ret(4'b0011, 'h70, 'h71, 0, 0);
    step();
    expect_out("pre_flush2", 1, 'h70, 1, 'h71, 2, 1);
    flush_i = 1'b1;
    set_ret(4'b1111, 'h60, 'h61, 'h62, 'h63);
    step();
    flush_i = 1'b0;
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("flush2", 0, 0, 0, 0, 0, 1);
    step();
    expect_out("flush2_idle", 0, 0, 0, 0, 0, 1);

    // Reset mid-drain discards entries.
    set_ret(4'b0111, 'h01, 'h02, 'h03, 0);
    step();
    set_ret(4'b0000, 0, 0, 0, 0);
    expect_out("pre_reset", 1, 'h01, 1, 'h02, 3, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    expect_out("mid_reset", 0, 0, 0, 0, 0, 1);
    step();
    expect_out("after_reset", 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
